// File: rtl/c_drain_pkg.sv
// Shared types and constants for the C result-bank drain sequencer.
package c_drain_pkg;

  localparam int BANK_CNT_WTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } c_drain_state_e;

  // The skid FIFO must absorb every read already in the SRAM pipe plus one.
  function automatic bit fifo_depth_ok(int fifo_depth, int rd_delay);
    return fifo_depth >= rd_delay + 1;
  endfunction

endpackage

// File: rtl/c_drain_fifo.sv
// Synchronous first-word-fall-through skid FIFO for drained result words.
// C_DRAIN_TLAST_EN adds a per-entry last bit alongside the data.
module c_drain_fifo #(
  parameter int D_WIDTH    = 64,
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [D_WIDTH-1:0] wr_data,
`ifdef C_DRAIN_TLAST_EN
  input  logic               wr_last,
  output logic               rd_last,
`endif
  input  logic               rd_en,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  logic [D_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               full;
  logic               do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({wr_en, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

`ifdef C_DRAIN_TLAST_EN
  logic last_mem [FIFO_DEPTH];

  assign rd_last = last_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) last_mem[wr_ptr] <= wr_last;
  end
`endif

  // The read-credit scheme upstream must never let a write hit a full FIFO.
  assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/c_drain_ctrl.sv
// Drains the idle C result bank over a valid/ready stream after each bank swap.
// C_DRAIN_TLAST_EN drives m_last on the word at the bank's final address.
module c_drain_ctrl
  import c_drain_pkg::*;
#(
  parameter int D_WIDTH    = 64,
  parameter int ADDR_WTH   = 2,
  parameter int RD_DELAY   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trigger_in,
  output logic                    rd_en_out,
  output logic [ADDR_WTH-1:0]     rd_addr_out,
  input  logic [D_WIDTH-1:0]      rd_data_in,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [D_WIDTH-1:0]      m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    overrun,
  output logic [BANK_CNT_WTH-1:0] bank_count,
  output c_drain_state_e          state_dbg
);

  localparam logic [ADDR_WTH-1:0] LAST_ADDR = '1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + RD_DELAY + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  if (!fifo_depth_ok(FIFO_DEPTH, RD_DELAY)) begin : g_depth_check
    $error("c_drain_ctrl: FIFO_DEPTH must be at least RD_DELAY+1");
  end

  c_drain_state_e      state;
  logic                trig_q;
  logic                pending;
  logic [ADDR_WTH-1:0] issue_addr;
  logic [RD_DELAY-1:0] vld_pipe;
  logic [CNT_W-1:0]    inflight_count;
  logic [FCNT_W-1:0]   fifo_count;
  logic                fifo_empty;
  logic                toggle;
  logic                issue;

  assign toggle = (trigger_in != trig_q);
  // Issue only while the FIFO can hold every word already requested.
  assign issue  = (state == DRAIN) &&
                  ((CNT_W'(fifo_count) + inflight_count) < CNT_W'(FIFO_DEPTH));

  assign rd_en_out   = issue;
  assign rd_addr_out = issue_addr;
  assign m_valid     = !fifo_empty;
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < RD_DELAY; i++) begin
      inflight_count = inflight_count + CNT_W'(vld_pipe[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      trig_q     <= 1'b0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      issue_addr <= '0;
      bank_count <= '0;
    end else begin
      trig_q <= trigger_in;
      // One swap may queue behind the active drain; a further one is lost.
      if (toggle && state != IDLE) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (toggle || pending) begin
            state      <= DRAIN;
            issue_addr <= '0;
            pending    <= toggle && pending;
          end
        end
        DRAIN: begin
          if (issue) begin
            issue_addr <= issue_addr + ADDR_WTH'(1);
            if (issue_addr == LAST_ADDR) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (inflight_count == '0 && fifo_empty) begin
            state      <= IDLE;
            bank_count <= bank_count + BANK_CNT_WTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      for (int i = 1; i < RD_DELAY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

`ifdef C_DRAIN_TLAST_EN
  logic [RD_DELAY-1:0] last_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_pipe <= '0;
    end else begin
      last_pipe[0] <= issue && (issue_addr == LAST_ADDR);
      for (int i = 1; i < RD_DELAY; i++) last_pipe[i] <= last_pipe[i-1];
    end
  end
`endif

  c_drain_fifo #(
    .D_WIDTH    (D_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld_pipe[RD_DELAY-1]),
    .wr_data (rd_data_in),
`ifdef C_DRAIN_TLAST_EN
    .wr_last (last_pipe[RD_DELAY-1]),
    .rd_last (m_last),
`endif
    .rd_en   (m_ready),
    .rd_data (m_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifndef C_DRAIN_TLAST_EN
  assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_c_drain_ctrl.sv
// Directed bench for c_drain_ctrl: default instance plus a 16-word / RD_DELAY=3 instance.
module tb_c_drain_ctrl;
  import c_drain_pkg::*;

`ifdef C_DRAIN_TLAST_EN
  localparam bit LAST_ON = 1'b1;
`else
  localparam bit LAST_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic        trig = 1'b0, m_ready = 1'b1;
  logic        rd_en, m_valid, m_last, busy, overrun;
  logic [1:0]  rd_addr;
  logic [63:0] rd_data, m_data;
  logic [15:0] bank_count;
  c_drain_state_e st1;

  // sweep instance
  logic        trig2 = 1'b0, m2_ready = 1'b1;
  logic        rd_en2, m2_valid, m2_last, busy2, overrun2;
  logic [3:0]  rd_addr2;
  logic [63:0] rd_data2, m2_data;
  logic [15:0] bank_count2;
  c_drain_state_e st2;

  c_drain_ctrl u_dut (
    .clk(clk), .rst(rst), .trigger_in(trig), .rd_en_out(rd_en), .rd_addr_out(rd_addr),
    .rd_data_in(rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .overrun(overrun), .bank_count(bank_count), .state_dbg(st1)
  );

  c_drain_ctrl #(.D_WIDTH(64), .ADDR_WTH(4), .RD_DELAY(3), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .trigger_in(trig2), .rd_en_out(rd_en2), .rd_addr_out(rd_addr2),
    .rd_data_in(rd_data2), .m_valid(m2_valid), .m_ready(m2_ready), .m_data(m2_data),
    .m_last(m2_last), .busy(busy2), .overrun(overrun2), .bank_count(bank_count2), .state_dbg(st2)
  );

  // SRAM read models: word = base + address, RD_DELAY cycles after rd_en
  logic [1:0] a1_q [2];
  logic [3:0] a2_q [3];
  always @(posedge clk) begin
    a1_q[0] <= rd_addr;
    a1_q[1] <= a1_q[0];
    a2_q[0] <= rd_addr2;
    a2_q[1] <= a2_q[0];
    a2_q[2] <= a2_q[1];
  end
  assign rd_data  = 64'hA0  + 64'(a1_q[1]);
  assign rd_data2 = 64'h100 + 64'(a2_q[2]);

  // scoreboard
  logic [64:0] exp_q[$];
  logic [64:0] exp2_q[$];
  logic [64:0] exp_w;
  logic [3:0]  exp_addr2 = '0;
  int checks = 0, failures = 0;
  int issue1_cnt = 0, issue2_cnt = 0, out1_cnt = 0;

  task automatic check(string tag, logic [64:0] obs, logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bank1();
    for (int i = 0; i < 4; i++) exp_q.push_back({LAST_ON && (i == 3), 64'hA0 + 64'(i)});
  endtask

  task automatic push_bank2();
    for (int i = 0; i < 16; i++) exp2_q.push_back({LAST_ON && (i == 15), 64'h100 + 64'(i)});
  endtask

  // driver: score this cycle's handshakes and issues, then advance one clock
  task automatic tick();
    if (m_valid && m_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL stream1_extra: observed %0h expected none", m_data);
      end
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check("stream1", {m_last, m_data}, exp_w);
      end
      out1_cnt++;
    end
    if (m2_valid && m2_ready) begin
      checks++;
      assert (exp2_q.size() > 0) else begin
        failures++;
        $error("FAIL stream2_extra: observed %0h expected none", m2_data);
      end
      if (exp2_q.size() > 0) begin
        exp_w = exp2_q.pop_front();
        check("stream2", {m2_last, m2_data}, exp_w);
      end
    end
    if (rd_en) issue1_cnt++;
    if (rd_en2) begin
      check("addr2", 65'(rd_addr2), 65'(exp_addr2));
      exp_addr2 = exp_addr2 + 4'd1;
      issue2_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; trig = 1'b0; trig2 = 1'b0; m_ready = 1'b1; m2_ready = 1'b1;
    tick();
    tick();
    exp_q.delete();
    exp2_q.delete();
    exp_addr2 = '0;
    rst = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    for (int i = 0; i < 40 && busy; i++) tick();
    check(tag, 65'(busy), 65'(0));
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_rd_en", 65'(rd_en), 65'(0));
    check("rst_m_valid", 65'(m_valid), 65'(0));
    check("rst_m_last", 65'(m_last), 65'(0));
    check("rst_busy", 65'(busy), 65'(0));
    check("rst_overrun", 65'(overrun), 65'(0));
    check("rst_bank_count", 65'(bank_count), 65'(0));
    check("rst_state", 65'(st1), 65'(IDLE));

    // 1: basic drain, m_ready high
    trig = 1'b1;
    push_bank1();
    tick();
    check("t1_rd_en", 65'(rd_en), 65'(1));
    check("t1_addr0", 65'(rd_addr), 65'(0));
    check("t1_busy", 65'(busy), 65'(1));
    tick();
    check("t1_addr1", 65'(rd_addr), 65'(1));
    tick();
    check("t1_addr2", 65'(rd_addr), 65'(2));
    check("t1_no_valid_yet", 65'(m_valid), 65'(0));
    tick();
    check("t1_addr3", 65'(rd_addr), 65'(3));
    check("t1_first_valid", 65'(m_valid), 65'(1));
    tick();
    check("t1_issue_done", 65'(rd_en), 65'(0));
    wait_idle("t1_idle");
    check("t1_bank_count", 65'(bank_count), 65'(1));
    check("t1_all_out", 65'(exp_q.size()), 65'(0));

    // 2: backpressure
    m_ready = 1'b0;
    trig = 1'b0;
    push_bank1();
    issue1_cnt = 0;
    repeat (6) tick();
    check("t2_hold_mid", 65'(m_data), 65'h0A0);
    repeat (6) tick();
    check("t2_issue_cnt", 65'(issue1_cnt), 65'(4));
    check("t2_valid", 65'(m_valid), 65'(1));
    check("t2_hold_end", 65'(m_data), 65'h0A0);
    m_ready = 1'b1;
    wait_idle("t2_idle");
    check("t2_bank_count", 65'(bank_count), 65'(2));
    check("t2_all_out", 65'(exp_q.size()), 65'(0));

    // 3: back-to-back swaps
    trig = 1'b1;
    push_bank1();
    push_bank1();
    tick();
    tick();
    trig = 1'b0;
    tick();
    for (int i = 0; i < 30 && st1 != IDLE; i++) tick();
    check("t3_gap_idle", 65'(st1), 65'(IDLE));
    tick();
    check("t3_restart_state", 65'(st1), 65'(DRAIN));
    check("t3_restart_rd_en", 65'(rd_en), 65'(1));
    check("t3_restart_addr", 65'(rd_addr), 65'(0));
    wait_idle("t3_idle");
    check("t3_bank_count", 65'(bank_count), 65'(4));
    check("t3_overrun", 65'(overrun), 65'(0));
    check("t3_all_out", 65'(exp_q.size()), 65'(0));

    // 4: overrun
    do_reset();
    trig = 1'b1;
    push_bank1();
    push_bank1();
    tick();
    tick();
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    check("t4_overrun_set", 65'(overrun), 65'(1));
    wait_idle("t4_idle_a");
    tick();
    wait_idle("t4_idle_b");
    repeat (5) tick();
    check("t4_bank_count", 65'(bank_count), 65'(2));
    check("t4_busy", 65'(busy), 65'(0));
    check("t4_overrun_sticky", 65'(overrun), 65'(1));
    check("t4_all_out", 65'(exp_q.size()), 65'(0));

    // 5: reset mid-drain
    trig = 1'b0;
    push_bank1();
    out1_cnt = 0;
    for (int i = 0; i < 20 && out1_cnt < 2; i++) tick();
    check("t5_two_out", 65'(out1_cnt), 65'(2));
    rst = 1'b1;
    tick();
    check("t5_rd_en", 65'(rd_en), 65'(0));
    check("t5_m_valid", 65'(m_valid), 65'(0));
    check("t5_m_last", 65'(m_last), 65'(0));
    check("t5_busy", 65'(busy), 65'(0));
    check("t5_overrun", 65'(overrun), 65'(0));
    check("t5_bank_count", 65'(bank_count), 65'(0));
    exp_q.delete();
    rst = 1'b0;
    tick();
    check("t5_still_empty", 65'(m_valid), 65'(0));
    trig = 1'b1;
    push_bank1();
    tick();
    check("t5_fresh_addr0", 65'(rd_addr), 65'(0));
    check("t5_fresh_rd_en", 65'(rd_en), 65'(1));
    wait_idle("t5_idle");
    check("t5_bank_count_after", 65'(bank_count), 65'(1));
    check("t5_all_out", 65'(exp_q.size()), 65'(0));

    // 6: 16-word banks, RD_DELAY=3, credit limit, random m_ready
    m2_ready = 1'b0;
    trig2 = 1'b1;
    push_bank2();
    issue2_cnt = 0;
    repeat (15) tick();
    check("t6_credit_issues", 65'(issue2_cnt), 65'(4));
    check("t6_valid", 65'(m2_valid), 65'(1));
    check("t6_hold", 65'(m2_data), 65'h100);
    trig2 = 1'b0;
    push_bank2();
    for (int i = 0; i < 3000 && !(bank_count2 == 16'd2 && !busy2); i++) begin
      m2_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("t6_bank_count", 65'(bank_count2), 65'(2));
    check("t6_busy", 65'(busy2), 65'(0));
    check("t6_overrun", 65'(overrun2), 65'(0));
    check("t6_issue_total", 65'(issue2_cnt), 65'(32));
    check("t6_all_out", 65'(exp2_q.size()), 65'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
